// File: rtl/pc_fetch_if.sv
// Fetch-stage bundle: control from decode/execute in, PC and status out.
// The master modport belongs to pc_fetch; the slave modport to whoever drives its controls.
interface pc_fetch_if #(
    parameter int unsigned tamanho = 32
);
    logic               stall;
    logic               branch_taken;
    logic [tamanho-1:0] branch_offset;
    logic               jump;
    logic [25:0]        jump_target;
    logic               jr;
    logic [tamanho-1:0] jr_addr;
    logic               halt_req;
    logic [tamanho-1:0] Address;
    logic [tamanho-1:0] pc_plus4;
    logic               running;
    logic               fault;
    logic [tamanho-1:0] fault_pc;
    logic [31:0]        fetch_count;

    modport master (
        input  stall, branch_taken, branch_offset, jump, jump_target, jr, jr_addr, halt_req,
        output Address, pc_plus4, running, fault, fault_pc, fetch_count
    );

    modport slave (
        output stall, branch_taken, branch_offset, jump, jump_target, jr, jr_addr, halt_req,
        input  Address, pc_plus4, running, fault, fault_pc, fetch_count
    );
endinterface

// File: rtl/pc_fetch.sv
// Program counter and fetch sequencer: next-PC select, target validation,
// boot/run/halt/fault control and a count of PC advances.
module pc_fetch #(
    parameter int unsigned       tamanho       = 32,
    parameter int unsigned       enderecamento = 10,
    parameter logic [tamanho-1:0] PC_RESET     = '0
) (
    input logic        clk,
    input logic        reset,
    pc_fetch_if.master bus
);

    typedef enum logic [1:0] {Boot, Run, Halted, Fault} state_t;

    localparam int unsigned hi_lsb = enderecamento + 2;

    state_t             state_q, state_d;
    logic [tamanho-1:0] pc_q, pc_d;
    logic [tamanho-1:0] fault_pc_q, fault_pc_d;
    logic [31:0]        fetch_count_q, fetch_count_d;
    logic [tamanho-1:0] pc_plus4;
    logic [tamanho-1:0] candidate;
    logic               cand_valid;

    assign pc_plus4 = pc_q + tamanho'(4);

    always_comb begin
        if (bus.jr) begin
            candidate = bus.jr_addr;
        end else if (bus.jump) begin
            candidate = {pc_plus4[tamanho-1 -: 4], bus.jump_target, 2'b00};
        end else if (bus.branch_taken) begin
            candidate = pc_plus4 + (bus.branch_offset << 2);
        end else begin
            candidate = pc_plus4;
        end
    end

    // Word aligned and inside the instruction memory; the 0xFFFF_FFFC wrap lands here too.
    assign cand_valid = (candidate[1:0] == 2'b00) && ((candidate >> hi_lsb) == '0);

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        fault_pc_d    = fault_pc_q;
        fetch_count_d = fetch_count_q;
        unique case (state_q)
            Boot: state_d = Run;
            Run: begin
                if (!bus.stall) begin
                    if (bus.halt_req) begin
                        state_d = Halted;
                    end else if (!cand_valid) begin
                        state_d    = Fault;
                        fault_pc_d = candidate;
                    end else begin
                        pc_d          = candidate;
                        fetch_count_d = fetch_count_q + 32'd1;
                    end
                end
            end
            Halted: state_d = Halted;
            Fault:  state_d = Fault;
            default: state_d = Boot;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= Boot;
            pc_q          <= PC_RESET;
            fault_pc_q    <= '0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fault_pc_q    <= fault_pc_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign bus.Address     = pc_q;
    assign bus.pc_plus4    = pc_plus4;
    assign bus.running     = (state_q == Run);
    assign bus.fault       = (state_q == Fault);
    assign bus.fault_pc    = fault_pc_q;
    assign bus.fetch_count = fetch_count_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: reset/boot, select priority, branch arithmetic,
// faults, stall and halt, each step checked against hand-computed values.
module tb_pc_fetch;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    pc_fetch_if #(.tamanho(32)) bus ();

    pc_fetch #(
        .tamanho      (32),
        .enderecamento(10),
        .PC_RESET     (32'h0000_0000)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and land 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.stall         = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_offset = 32'h0;
        bus.jump          = 1'b0;
        bus.jump_target   = 26'h0;
        bus.jr            = 1'b0;
        bus.jr_addr       = 32'h0;
        bus.halt_req      = 1'b0;
    endtask

    task automatic check_state(input string tag, input logic [31:0] addr, input logic [31:0] cnt,
                               input logic run, input logic flt, input logic [31:0] fpc);
        check({tag, ".Address"}, bus.Address, addr);
        check({tag, ".pc_plus4"}, bus.pc_plus4, addr + 32'd4);
        check({tag, ".fetch_count"}, bus.fetch_count, cnt);
        check({tag, ".running"}, {31'd0, bus.running}, {31'd0, run});
        check({tag, ".fault"}, {31'd0, bus.fault}, {31'd0, flt});
        check({tag, ".fault_pc"}, bus.fault_pc, fpc);
    endtask

    // Asynchronous reset between edges, held over one edge, released mid-cycle.
    task automatic do_reset(input string tag);
        idle_inputs();
        reset = 1'b1;
        #1;
        check_state({tag, ".async"}, 32'h0, 32'd0, 1'b0, 1'b0, 32'h0);
        step();
        check_state({tag, ".held"}, 32'h0, 32'd0, 1'b0, 1'b0, 32'h0);
        reset = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        idle_inputs();
        #2;
        do_reset("por");

        // Boot ignores inputs: stall and halt_req present only on the boot edge.
        bus.stall    = 1'b1;
        bus.halt_req = 1'b1;
        step();
        check_state("boot", 32'h0, 32'd0, 1'b1, 1'b0, 32'h0);
        idle_inputs();
        step();
        check_state("seq1", 32'h4, 32'd1, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 15; i++) step();
        check_state("seq16", 32'h40, 32'd16, 1'b1, 1'b0, 32'h0);

        // Mid-run reset at PC = 0x40.
        #2;
        do_reset("midrun");
        step();
        check_state("reboot", 32'h0, 32'd0, 1'b1, 1'b0, 32'h0);
        step();
        check_state("reboot.seq", 32'h4, 32'd1, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) step();
        check_state("at10", 32'h10, 32'd4, 1'b1, 1'b0, 32'h0);

        // Priority: jr beats jump beats branch.
        bus.jr            = 1'b1;
        bus.jr_addr       = 32'h80;
        bus.jump          = 1'b1;
        bus.jump_target   = 26'h20;
        bus.branch_taken  = 1'b1;
        bus.branch_offset = 32'h40;
        step();
        check_state("prio.jr", 32'h80, 32'd5, 1'b1, 1'b0, 32'h0);
        bus.jr = 1'b0;
        step();
        check_state("prio.jump", 32'h80, 32'd6, 1'b1, 1'b0, 32'h0);
        bus.jump        = 1'b0;
        bus.jump_target = 26'h3FF;
        step();
        check_state("prio.branch", 32'h184, 32'd7, 1'b1, 1'b0, 32'h0);

        // Branch arithmetic with negative and positive offsets.
        bus.branch_taken = 1'b0;
        bus.jr           = 1'b1;
        bus.jr_addr      = 32'h100;
        step();
        check_state("jr100", 32'h100, 32'd8, 1'b1, 1'b0, 32'h0);
        bus.jr            = 1'b0;
        bus.branch_taken  = 1'b1;
        bus.branch_offset = 32'hFFFF_FFFC;
        step();
        check_state("br.neg", 32'hF4, 32'd9, 1'b1, 1'b0, 32'h0);
        bus.branch_offset = 32'h3;
        step();
        check_state("br.pos", 32'h104, 32'd10, 1'b1, 1'b0, 32'h0);

        // Stall three cycles with an invalid jr pending: everything frozen.
        bus.branch_taken = 1'b0;
        bus.stall        = 1'b1;
        bus.jr           = 1'b1;
        bus.jr_addr      = 32'h22;
        for (int i = 0; i < 3; i++) begin
            step();
            check_state("stall", 32'h104, 32'd10, 1'b1, 1'b0, 32'h0);
        end

        // Halt together with an invalid target: halt wins, no fault.
        bus.stall    = 1'b0;
        bus.halt_req = 1'b1;
        bus.jr_addr  = 32'h3;
        step();
        check_state("halt", 32'h104, 32'd10, 1'b0, 1'b0, 32'h0);
        bus.halt_req = 1'b0;
        bus.jr_addr  = 32'h200;
        for (int i = 0; i < 10; i++) begin
            step();
            check_state("halted", 32'h104, 32'd10, 1'b0, 1'b0, 32'h0);
        end

        // Misaligned jr target faults; terminal afterwards.
        do_reset("pre.mis");
        step();
        step();
        check_state("mis.pre", 32'h4, 32'd1, 1'b1, 1'b0, 32'h0);
        bus.jr      = 1'b1;
        bus.jr_addr = 32'h22;
        step();
        check_state("mis.fault", 32'h4, 32'd1, 1'b0, 1'b1, 32'h22);
        bus.jr_addr = 32'h40;
        for (int i = 0; i < 3; i++) begin
            step();
            check_state("mis.hold", 32'h4, 32'd1, 1'b0, 1'b1, 32'h22);
        end

        // Sequential step off the top of instruction memory.
        do_reset("pre.oob");
        step();
        bus.jr      = 1'b1;
        bus.jr_addr = 32'hFFC;
        step();
        check_state("oob.pre", 32'hFFC, 32'd1, 1'b1, 1'b0, 32'h0);
        bus.jr = 1'b0;
        step();
        check_state("oob.fault", 32'hFFC, 32'd1, 1'b0, 1'b1, 32'h1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #20000;
        $display("FAIL timeout: observed no finish, expected finish before 20000");
        $fatal(1, "timeout");
    end

endmodule
